// File: rtl/vec2d_stream_checker.sv
// Receive-side checker for a row-major serialized ROWS x COLS tabulated array.
// Every element is compared against BASE + row + col, truncated to WIDTH bits.
// The checker reports an error count, a framing flag for a misplaced in_last,
// and where the first mismatch occurred. A run ends at the final position or
// at an early in_last, whichever comes first.
module vec2d_stream_checker #(
    parameter int unsigned ROWS  = 2,
    parameter int unsigned COLS  = 3,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BASE  = 1,
    parameter int unsigned ERR_W = 8,
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             framing_err,
    output logic [ROW_W-1:0] first_err_row,
    output logic [COL_W-1:0] first_err_col,
    output logic [WIDTH-1:0] first_err_data
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRecv = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e state;

    // Current element position within the array
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;

    // Per-beat decode
    logic             beat;
    logic [WIDTH-1:0] expected;
    logic             mismatch;
    logic             atLastCol;
    logic             atFinal;
    logic             terminate;
    logic [ERR_W-1:0] errNext;
    logic             framingNext;
    logic [ROW_W-1:0] rowNext;
    logic [COL_W-1:0] colNext;

    // Handshake and status flags come from the state register only, so
    // in_ready has no combinational path from in_valid.
    assign in_ready = (state == StRecv);
    assign busy     = (state == StRecv);
    assign done     = (state == StDone);

    // Beat evaluation: compare, framing check, saturating count, index advance
    always_comb begin
        beat      = in_valid && (state == StRecv);
        expected  = WIDTH'(BASE) + WIDTH'(row) + WIDTH'(col);
        mismatch  = beat && (in_data != expected);
        atLastCol = (col == COL_W'(COLS - 1));
        atFinal   = atLastCol && (row == ROW_W'(ROWS - 1));
        // A run ends at the final position, or earlier if the sender says so
        terminate = beat && (atFinal || in_last);

        errNext = err_count;
        if (mismatch && (err_count != {ERR_W{1'b1}})) begin
            errNext = err_count + ERR_W'(1);
        end

        // in_last must coincide exactly with the final position
        framingNext = framing_err || (beat && (atFinal != in_last));

        if (atLastCol) begin
            colNext = '0;
            rowNext = row + ROW_W'(1);
        end else begin
            colNext = col + COL_W'(1);
            rowNext = row;
        end
    end

    // Control FSM and all result registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= StIdle;
            row            <= '0;
            col            <= '0;
            pass           <= 1'b0;
            err_count      <= '0;
            framing_err    <= 1'b0;
            first_err_row  <= '0;
            first_err_col  <= '0;
            first_err_data <= '0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    // A new run starts from a clean slate
                    if (start) begin
                        state          <= StRecv;
                        row            <= '0;
                        col            <= '0;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        framing_err    <= 1'b0;
                        first_err_row  <= '0;
                        first_err_col  <= '0;
                        first_err_data <= '0;
                    end
                end
                StRecv: begin
                    if (beat) begin
                        err_count   <= errNext;
                        framing_err <= framingNext;
                        row         <= rowNext;
                        col         <= colNext;
                        // Count has not left zero yet, so this is the first miss
                        if (mismatch && (err_count == '0)) begin
                            first_err_row  <= row;
                            first_err_col  <= col;
                            first_err_data <= in_data;
                        end
                        if (terminate) begin
                            state <= StDone;
                            pass  <= (errNext == '0) && !framingNext;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec2d_stream_checker.sv
// Directed bench for vec2d_stream_checker (ROWS=2, COLS=3, BASE=1).
// A second instance with a 2-bit error counter shares the stimulus and is
// used to observe counter saturation.
module tb_vec2d_stream_checker;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;

    logic        in_ready, busy, done, pass, framing_err;
    logic [7:0]  err_count;
    logic [0:0]  first_err_row;
    logic [1:0]  first_err_col;
    logic [31:0] first_err_data;

    logic        readyS, busyS, doneS, passS, framS;
    logic [1:0]  errS;
    logic [0:0]  rowS;
    logic [1:0]  colS;
    logic [31:0] dataS;

    int nCmp = 0;
    int nFail = 0;
    int beatCount = 0;

    vec2d_stream_checker #(
        .ROWS(2), .COLS(3), .WIDTH(32), .BASE(1), .ERR_W(8)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .framing_err(framing_err), .first_err_row(first_err_row),
        .first_err_col(first_err_col), .first_err_data(first_err_data)
    );

    vec2d_stream_checker #(
        .ROWS(2), .COLS(3), .WIDTH(32), .BASE(1), .ERR_W(2)
    ) dutSat (
        .clock(clock), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(readyS), .in_data(in_data), .in_last(in_last),
        .busy(busyS), .done(doneS), .pass(passS), .err_count(errS),
        .framing_err(framS), .first_err_row(rowS),
        .first_err_col(colS), .first_err_data(dataS)
    );

    always #5 clock = ~clock;

    // Count accepted beats on the main instance
    always @(posedge clock) begin
        if (reset && in_valid && in_ready) beatCount++;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat transferred
    task automatic sendBeat(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) check("beat_timeout", 64'd0, 64'd1);
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        idle(3);

        // Reset state
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        reset = 1'b1;
        idle(1);
        check("idle_busy", busy, 0);

        // 1: correct stream, back-to-back
        pulseStart();
        check("t1_ready_after_start", in_ready, 1);
        beatCount = 0;
        sendBeat(1, 0); sendBeat(2, 0); sendBeat(3, 0);
        sendBeat(2, 0); sendBeat(3, 0);
        check("t1_done_before_last", done, 0);
        sendBeat(4, 1);
        check("t1_done", done, 1);
        check("t1_pass", pass, 1);
        check("t1_err", err_count, 0);
        check("t1_framing", framing_err, 0);
        check("t1_ready_done", in_ready, 0);
        check("t1_beats", beatCount, 6);

        // 2: 5th value wrong, stalls between beats
        pulseStart();
        beatCount = 0;
        sendBeat(1, 0); idle($urandom_range(0, 3));
        sendBeat(2, 0); idle($urandom_range(0, 3));
        sendBeat(3, 0); idle($urandom_range(0, 3));
        sendBeat(2, 0); idle($urandom_range(0, 3));
        sendBeat(7, 0); idle($urandom_range(0, 3));
        sendBeat(4, 1);
        check("t2_done", done, 1);
        check("t2_err", err_count, 1);
        check("t2_row", first_err_row, 1);
        check("t2_col", first_err_col, 1);
        check("t2_data", first_err_data, 7);
        check("t2_pass", pass, 0);
        check("t2_beats", beatCount, 6);

        // 3: early in_last on beat 4; restart from a failed run clears state
        pulseStart();
        check("t3_clear_err", err_count, 0);
        check("t3_clear_data", first_err_data, 0);
        check("t3_clear_row", first_err_row, 0);
        beatCount = 0;
        sendBeat(1, 0); sendBeat(2, 0); sendBeat(3, 0);
        sendBeat(2, 1);
        check("t3_done", done, 1);
        check("t3_framing", framing_err, 1);
        check("t3_err", err_count, 0);
        check("t3_pass", pass, 0);
        in_valid = 1'b1; in_data = 32'd3;
        idle(3);
        in_valid = 1'b0;
        check("t3_ready", in_ready, 0);
        check("t3_beats", beatCount, 4);
        check("t3_done_hold", done, 1);

        // 4: all zeros -> six mismatches; 2-bit counter saturates
        pulseStart();
        for (int i = 0; i < 5; i++) sendBeat(0, 0);
        sendBeat(0, 1);
        check("t4_sat_err", errS, 3);
        check("t4_err", err_count, 6);
        check("t4_sat_row", rowS, 0);
        check("t4_sat_col", colS, 0);
        check("t4_sat_data", dataS, 0);
        check("t4_sat_pass", passS, 0);
        check("t4_sat_done", doneS, 1);

        // 6: from failed DONE, correct stream with a stray start mid-run
        pulseStart();
        check("t6_clear_err", err_count, 0);
        sendBeat(1, 0); sendBeat(2, 0);
        start = 1'b1;
        idle(1);
        start = 1'b0;
        check("t6_busy_after_start", busy, 1);
        sendBeat(3, 0); sendBeat(2, 0); sendBeat(3, 0); sendBeat(4, 1);
        check("t6_pass", pass, 1);
        check("t6_err", err_count, 0);
        check("t6_framing", framing_err, 0);

        // 5: reset mid-transfer, then a clean run
        pulseStart();
        sendBeat(9, 0); sendBeat(9, 0); sendBeat(9, 0);
        check("t5_err_pre", err_count, 3);
        check("t5_data_pre", first_err_data, 9);
        reset = 1'b0;
        idle(1);
        check("t5_rst_ready", in_ready, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_err", err_count, 0);
        check("t5_rst_data", first_err_data, 0);
        check("t5_rst_framing", framing_err, 0);
        check("t5_rst_sat_err", errS, 0);
        idle(1);
        reset = 1'b1;
        idle(1);
        check("t5_idle_done", done, 0);
        pulseStart();
        sendBeat(1, 0); sendBeat(2, 0); sendBeat(3, 0);
        sendBeat(2, 0); sendBeat(3, 0); sendBeat(4, 1);
        check("t5_done", done, 1);
        check("t5_pass", pass, 1);
        check("t5_err", err_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
